mc_controller: RTL
==================

# mc_controller

Multicycle MIPS control unit that drives the multicycle datapath. It consumes `opcode`, `funct` and `Zero` from the datapath and produces every datapath select and write-enable, plus the memory write strobe. It is a Moore FSM with one combinational Mealy term: branch PC enable.

## Interface
Parameters: none.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low. Low forces the state to FETCH and clears `badop`.
- `opcode` in 6: Instr[31:26] from datapath.
- `funct` in 6: Instr[5:0] from datapath.
- `Zero` in 1: ALU zero flag from datapath.
- `PCEn` out 1: PC register write enable.
- `IRWrite` out 1: instruction register write enable.
- `RegWrite` out 1: register file write enable.
- `MemWrite` out 1: data memory write strobe.
- `RegDst` out 1: 0 selects rt, 1 selects rd.
- `ALUSrcA` out 1: 0 selects PC, 1 selects A.
- `ALUSrcB` out 2: 00 B, 01 constant 4, 10 SignImm, 11 SignImm<<2.
- `ALUControl` out 4: ALU operation code.
- `PCSrc` out 1: 0 selects ALUResult, 1 selects ALUOut.
- `MemToReg` out 1: 0 selects ALUOut, 1 selects Data.
- `IorD` out 1: 0 selects PC address, 1 selects ALUOut address.
- `state` out 4: current state encoding, for debug and bench.
- `badop` out 1: sticky flag, set when an unsupported opcode or funct is decoded.

## Operation
- ALUControl encodings: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000.
- Supported funct values for R-type: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10. Codes 11–15 are unreachable; if entered, the FSM returns to FETCH.
- Any output not listed for a state is 0.
- Per-state outputs:
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=0, IRWrite=1, PCEn=1. Next state is DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ADD (branch target into ALUOut). Next state: lw/sw → MEMADR; R → EXEC; beq → BRANCH; addi → ADDIEX; other → FETCH and set `badop`.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next state: lw → MEMRD; sw → MEMWR.
  - MEMRD: IorD=1. Next state is MEMWB.
  - MEMWB: RegDst=0, MemToReg=1, RegWrite=1. Next state is FETCH.
  - MEMWR: IorD=1, MemWrite=1. Next state is FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from funct. Next state: legal funct → ALUWB; illegal funct → FETCH, ALUControl=ADD, set `badop`, no register write.
  - ALUWB: RegDst=1, MemToReg=0, RegWrite=1. Next state is FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=1, PCEn=Zero (combinational). Next state is FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD. Next state is ADDIWB.
  - ADDIWB: RegDst=0, MemToReg=0, RegWrite=1. Next state is FETCH.
- Decisions in DECODE and MEMADR use the live `opcode`. Instr is stable after FETCH, so this is safe.
- `badop` only sets; it clears only on reset.

## Timing
- Reset values (state=FETCH):
  - Asserted: PCEn=1, IRWrite=1, ALUSrcB=01, ALUControl=0010.
  - Zero: all other outputs, and `badop`, `state`.
  - The datapath is held in reset concurrently, so these enables are harmless.
- The state register updates on the rising clk edge after `reset` deasserts. The first FETCH completes on that edge.
- Instruction cycle counts, FETCH through last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal opcode 2, illegal funct 3.
- `Zero` is sampled only in BRANCH. PCEn follows it combinationally in that state; Zero toggling in any other state has no effect.
- Outputs are glitch-free with respect to state: they are decoded from registered state only, except the BRANCH PCEn term.
- Asynchronous reset mid-instruction: state goes to FETCH immediately. Any pending write-enable drops within the same cycle.

## Test plan
- Reset hold then release: while reset=0, state=0, badop=0, PCEn=1, IRWrite=1. After release, the state sequence is 0,1.
- lw (opcode 100011): states 0,1,2,3,4,0. In state 3, IorD=1. In state 4, MemToReg=1, RegWrite=1, RegDst=0. MemWrite=0 throughout.
- sw (opcode 101011): states 0,1,2,5,0. MemWrite=1 in exactly one cycle, with IorD=1. RegWrite is never 1.
- R-type funct sweep (100000, 100010, 100100, 100101, 101010): in EXEC, ALUControl = 0010, 0110, 0000, 0001, 0111 respectively. ALUWB has RegDst=1.
- beq (opcode 000100): with Zero=1 in BRANCH, PCEn=1 and PCSrc=1. With Zero=0, PCEn=0. Zero=1 driven during DECODE causes no PCEn.
- Illegal opcode 111111: states 0,1,0, badop=1 thereafter. Illegal funct 000111: states 0,1,6,0, RegWrite never 1, badop=1. A following reset clears badop.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: Moore outputs registered alongside the state,
// plus the combinational branch PC-enable term.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic       PCSrc,
  output logic       MemToReg,
  output logic       IorD,
  output logic [3:0] state,
  output logic       badop
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
  } state_t;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluctl;
    logic       pcsrc;
    logic       memtoreg;
    logic       iord;
  } ctrl_t;

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       badop_q, badop_d;
  logic       funct_ok;
  logic [3:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Instr is held in IR after FETCH, so live opcode/funct are stable here.
  always_comb begin
    state_d = S_FETCH;
    badop_d = badop_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d = S_FETCH;
            badop_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC: begin
        if (funct_ok) begin
          state_d = S_ALUWB;
        end else begin
          state_d = S_FETCH;
          badop_d = 1'b1;
        end
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.pcen    = 1'b1;
        ctrl_d.irwrite = 1'b1;
        ctrl_d.alusrcb = 2'b01;
        ctrl_d.aluctl  = ALU_ADD;
      end
      S_DECODE: begin
        ctrl_d.alusrcb = 2'b11;
        ctrl_d.aluctl  = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_d.alusrca = 1'b1;
        ctrl_d.alusrcb = 2'b10;
        ctrl_d.aluctl  = ALU_ADD;
      end
      S_MEMRD: ctrl_d.iord = 1'b1;
      S_MEMWB: begin
        ctrl_d.memtoreg = 1'b1;
        ctrl_d.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.iord     = 1'b1;
        ctrl_d.memwrite = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.alusrca = 1'b1;
        ctrl_d.aluctl  = funct_ok ? funct_alu : ALU_ADD;
      end
      S_ALUWB: begin
        ctrl_d.regdst   = 1'b1;
        ctrl_d.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alusrca = 1'b1;
        ctrl_d.aluctl  = ALU_SUB;
        ctrl_d.pcsrc   = 1'b1;
      end
      S_ADDIWB: ctrl_d.regwrite = 1'b1;
      default:  ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_FETCH;
      badop_q        <= 1'b0;
      ctrl_q         <= '0;
      ctrl_q.pcen    <= 1'b1;
      ctrl_q.irwrite <= 1'b1;
      ctrl_q.alusrcb <= 2'b01;
      ctrl_q.aluctl  <= ALU_ADD;
    end else begin
      state_q <= state_d;
      badop_q <= badop_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // The only non-registered term: branch taken follows Zero within BRANCH.
  assign PCEn       = ctrl_q.pcen | ((state_q == S_BRANCH) & Zero);
  assign IRWrite    = ctrl_q.irwrite;
  assign RegWrite   = ctrl_q.regwrite;
  assign MemWrite   = ctrl_q.memwrite;
  assign RegDst     = ctrl_q.regdst;
  assign ALUSrcA    = ctrl_q.alusrca;
  assign ALUSrcB    = ctrl_q.alusrcb;
  assign ALUControl = ctrl_q.aluctl;
  assign PCSrc      = ctrl_q.pcsrc;
  assign MemToReg   = ctrl_q.memtoreg;
  assign IorD       = ctrl_q.iord;
  assign state      = state_q;
  assign badop      = badop_q;

endmodule
